// File: rtl/eth_rx_frame_ctrl.sv
// Ethernet receive framer: preamble/SFD qualification, frame length and error classification, statistics.
// Optional runt classification (frames under 64 bytes) is compiled in when RX_RUNT_CHECK_EN is defined.
module eth_rx_frame_ctrl #(
  parameter int unsigned MIN_PREAMBLE = 6,
  parameter int unsigned MAX_LEN      = 1518,
  parameter int unsigned IFG_CYC      = 4
) (
  input  logic        rx_clk,
  input  logic        rst_n,
  input  logic        i_rx_dv,
  input  logic        i_rx_er,
  input  logic [7:0]  i_rx_data,
  input  logic        i_enable,
  input  logic        i_stat_clr,
  output logic        o_sfd_hit,
  output logic        o_frame_done,
  output logic [10:0] o_frame_len,
  output logic        o_frame_err,
  output logic [1:0]  o_err_code,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_err_cnt,
  output logic [2:0]  o_state
);

  localparam int unsigned IW = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DATA = 3'd2,
    S_DROP = 3'd3,
    S_IFG  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_pre_cnt;
  logic [3:0]    w_pre_cnt_nxt;
  logic [10:0]   r_len;
  logic [10:0]   w_len_nxt;
  logic          r_er_flag;
  logic          w_er_flag_nxt;
  logic [IW-1:0] r_ifg_cnt;
  logic [IW-1:0] w_ifg_cnt_nxt;
  logic          w_sfd_accept;
  logic          w_frame_end;
  logic [1:0]    w_err_code;
  logic          r_sfd_hit;
  logic          r_frame_done;
  logic [10:0]   r_frame_len;
  logic          r_frame_err;
  logic [1:0]    r_err_code;
  logic [15:0]   r_frame_cnt;
  logic [15:0]   r_err_cnt;

  // Error classification with priority rx_er > oversize > runt.
  function automatic logic [1:0] f_err_code(input logic er, input logic [10:0] len);
    logic [1:0] code;
    if (er) begin
      code = 2'd1;
    end else if (32'(len) > MAX_LEN) begin
      code = 2'd2;
`ifdef RX_RUNT_CHECK_EN
    end else if (len < 11'd64) begin
      code = 2'd3;
`endif
    end else begin
      code = 2'd0;
    end
    return code;
  endfunction

  assign w_err_code = f_err_code(r_er_flag, r_len);

  // FSM state register.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic plus next values of the per-frame working counters.
  always_comb begin
    w_state_nxt   = r_state;
    w_pre_cnt_nxt = r_pre_cnt;
    w_len_nxt     = r_len;
    w_er_flag_nxt = r_er_flag;
    w_ifg_cnt_nxt = r_ifg_cnt;
    w_sfd_accept  = 1'b0;
    w_frame_end   = 1'b0;
    if (!i_enable) begin
      // Abort wins over everything: any in-flight frame is silently discarded.
      w_state_nxt   = S_IDLE;
      w_pre_cnt_nxt = 4'd0;
      w_len_nxt     = 11'd0;
      w_er_flag_nxt = 1'b0;
      w_ifg_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_rx_dv) begin
            if (!i_rx_er && (i_rx_data == 8'h55)) begin
              w_state_nxt   = S_PRE;
              w_pre_cnt_nxt = 4'd1;
            end else begin
              w_state_nxt = S_DROP;
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_PRE: begin
          if (!i_rx_dv) begin
            w_state_nxt   = S_IDLE;
            w_pre_cnt_nxt = 4'd0;
          end else if (i_rx_er) begin
            w_state_nxt = S_DROP;
          end else if (i_rx_data == 8'h55) begin
            w_pre_cnt_nxt = (r_pre_cnt == 4'd15) ? 4'd15 : (r_pre_cnt + 4'd1);
          end else if ((i_rx_data == 8'hD5) && (32'(r_pre_cnt) >= MIN_PREAMBLE)) begin
            w_state_nxt   = S_DATA;
            w_len_nxt     = 11'd0;
            w_er_flag_nxt = 1'b0;
            w_sfd_accept  = 1'b1;
          end else begin
            w_state_nxt = S_DROP;
          end
        end
        S_DATA: begin
          if (i_rx_dv) begin
            w_len_nxt = (r_len == 11'h7FF) ? 11'h7FF : (r_len + 11'd1);
            if (i_rx_er) begin
              w_er_flag_nxt = 1'b1;
            end else begin
              w_er_flag_nxt = r_er_flag;
            end
          end else begin
            w_state_nxt   = S_IFG;
            w_ifg_cnt_nxt = '0;
            w_frame_end   = 1'b1;
          end
        end
        S_DROP: begin
          if (!i_rx_dv) begin
            w_state_nxt   = S_IFG;
            w_ifg_cnt_nxt = '0;
          end else begin
            w_state_nxt = S_DROP;
          end
        end
        S_IFG: begin
          if (i_rx_dv) begin
            w_state_nxt   = S_DROP;
            w_ifg_cnt_nxt = '0;
          end else if ((32'(r_ifg_cnt) + 32'd1) >= IFG_CYC) begin
            w_state_nxt   = S_IDLE;
            w_ifg_cnt_nxt = '0;
          end else begin
            w_ifg_cnt_nxt = r_ifg_cnt + IW'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Working counters, event pulses and the held per-frame result.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt    <= 4'd0;
      r_len        <= 11'd0;
      r_er_flag    <= 1'b0;
      r_ifg_cnt    <= '0;
      r_sfd_hit    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_len  <= 11'd0;
      r_frame_err  <= 1'b0;
      r_err_code   <= 2'd0;
    end else begin
      r_pre_cnt    <= w_pre_cnt_nxt;
      r_len        <= w_len_nxt;
      r_er_flag    <= w_er_flag_nxt;
      r_ifg_cnt    <= w_ifg_cnt_nxt;
      r_sfd_hit    <= w_sfd_accept;
      r_frame_done <= w_frame_end;
      if (w_frame_end) begin
        r_frame_len <= r_len;
        r_err_code  <= w_err_code;
        r_frame_err <= (w_err_code != 2'd0);
      end
    end
  end

  // Saturating statistics; a coincident clear takes precedence over the increment.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 16'd0;
    end else if (i_stat_clr) begin
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 16'd0;
    end else if (r_frame_done) begin
      if (r_frame_err) begin
        r_err_cnt <= (r_err_cnt == 16'hFFFF) ? 16'hFFFF : (r_err_cnt + 16'd1);
      end else begin
        r_frame_cnt <= (r_frame_cnt == 16'hFFFF) ? 16'hFFFF : (r_frame_cnt + 16'd1);
      end
    end
  end

  assign o_sfd_hit    = r_sfd_hit;
  assign o_frame_done = r_frame_done;
  assign o_frame_len  = r_frame_len;
  assign o_frame_err  = r_frame_err;
  assign o_err_code   = r_err_code;
  assign o_frame_cnt  = r_frame_cnt;
  assign o_err_cnt    = r_err_cnt;
  assign o_state      = r_state;

endmodule

// File: doc/eth_rx_frame_ctrl.md
ETH_RX_FRAME_CTRL -- requirements
Module: eth_rx_frame_ctrl

Interface
REQ-001 Parameter MIN_PREAMBLE, default 6: minimum count of 0x55 bytes before SFD for a frame to be accepted.
REQ-002 Parameter MAX_LEN, default 1518: largest legal frame length in bytes, counted after SFD and including FCS.
REQ-003 Parameter IFG_CYC, default 4: consecutive rx_dv-low cycles required in IFG before re-arming.
REQ-004 rx_clk  in  1  RGMII RX clock, single-data-rate byte domain; all logic SHALL be clocked on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 rx_dv  in  1  receive data valid, one byte per cycle.
REQ-007 rx_er  in  1  receive error.
REQ-008 rx_data  in  8  receive byte.
REQ-009 enable  in  1  high arms detection; low forces synchronous abort.
REQ-010 stat_clr  in  1  synchronous clear of both statistics counters.
REQ-011 sfd_hit  out  1  single-cycle pulse per accepted SFD; feeds the SFD LED display CDC toggle.
REQ-012 frame_done  out  1  single-cycle pulse at end of each accepted frame.
REQ-013 frame_len  out  11  byte count of the last completed frame, held until the next frame_done.
REQ-014 frame_err  out  1  qualifies frame_done: high means the frame had an error.
REQ-015 err_code  out  2  0 none, 1 rx_er, 2 oversize, 3 runt; held with frame_len.
REQ-016 frame_cnt  out  16  count of good frames, saturating.
REQ-017 err_cnt  out  16  count of errored frames, saturating.
REQ-018 state_o  out  3  current FSM state, for debug.

Function
REQ-019 The FSM SHALL have states IDLE=0, PRE=1, DATA=2, DROP=3, IFG=4; encodings 5-7 SHALL go to IDLE on the next cycle.
REQ-020 IDLE: rx_dv&!rx_er&data==0x55 -> PRE with pre_cnt=1; any other rx_dv=1 -> DROP; rx_dv=0 -> stay in IDLE.
REQ-021 PRE: rx_dv=0 -> IDLE with no pulse; rx_er -> DROP; 0x55 -> pre_cnt+1, saturating at 15; 0xD5 with pre_cnt>=MIN_PREAMBLE -> DATA with len=0; 0xD5 with pre_cnt<MIN_PREAMBLE -> DROP; any other byte -> DROP.
REQ-022 sfd_hit SHALL be registered and assert exactly one cycle, the cycle after the accepted SFD byte is sampled.
REQ-023 DATA: each rx_dv=1 cycle increments len, saturating at 2047; rx_er=1 with rx_dv=1 sets a sticky rx_er flag, the byte is still counted, and the state stays DATA.
REQ-024 DATA with rx_dv=0: the FSM SHALL go to IFG, and on the following cycle it SHALL pulse frame_done, update frame_len and err_code, and set frame_err=(err_code!=0).
REQ-025 err_code priority: rx_er flag > oversize (len>MAX_LEN) > runt (see REQ-034).
REQ-026 A frame with zero data bytes (SFD immediately followed by rx_dv=0) SHALL complete with frame_len=0.
REQ-027 DROP: wait for rx_dv=0, then go to IFG; no frame_done SHALL be produced.
REQ-028 IFG: count rx_dv=0 cycles; reaching IFG_CYC -> IDLE; rx_dv=1 before that -> clear the count and go to DROP.
REQ-029 enable=0: any state -> IDLE next cycle; a frame in DATA is discarded with no frame_done; no sfd_hit SHALL fire.
REQ-030 frame_cnt SHALL increment on frame_done with frame_err=0, err_cnt on frame_done with frame_err=1; both SHALL saturate at 0xFFFF.
REQ-031 If stat_clr and frame_done occur in the same cycle, the clear SHALL win and both counters SHALL read 0 on the next cycle.
REQ-032 sfd_hit and frame_done SHALL never assert in the same cycle.

Reset
REQ-033 On rst_n=0: state=IDLE, pre_cnt=0, len=0, flags=0, and all outputs 0, including frame_len, err_code, frame_cnt and err_cnt.

Configuration
REQ-034 Macro RX_RUNT_CHECK_EN: when defined, a frame with frame_len<64 and no higher-priority error SHALL report err_code=3 and frame_err=1; when undefined, runt detection logic SHALL be absent and err_code=3 SHALL never occur.

Verification
REQ-035 Stimulus: enable=1, 7x 0x55, 0xD5, 64 data bytes, then dv low. Required: one sfd_hit; frame_done with frame_len=64, err_code=0; frame_cnt=1.
REQ-036 Stimulus: 5x 0x55 then 0xD5 (MIN_PREAMBLE=6). Required: no sfd_hit, state goes DROP then IFG, no frame_done.
REQ-037 Stimulus: good preamble, 100 bytes with rx_er high on byte 50. Required: frame_done with frame_len=100, err_code=1, err_cnt=1.
REQ-038 Stimulus: 1600-byte frame. Required: err_code=2, frame_len=1600. Stimulus: 40-byte frame. Required with RX_RUNT_CHECK_EN: err_code=3; without it: err_code=0.
REQ-039 Stimulus: enable dropped mid-DATA. Required: IDLE next cycle, no frame_done. Stimulus: stat_clr coincident with frame_done. Required: both counters 0.
REQ-040 Stimulus: back-to-back frames with a 2-cycle gap (IFG_CYC=4). Required: second frame dropped with no sfd_hit, and the first frame's frame_len is retained.
